// File: rtl/ramtest_main.sv
// ramtest_main: SRAM tester for four 8-bit asynchronous SRAMs on one shared bus.
// Each pass writes an LFSR byte stream to every location of every chip, then
// reads everything back against the regenerated stream. led_err is sticky on
// any mismatch; led_ok toggles after every clean verify pass.
module ramtest_main #(
    parameter int ADDR_BITS = 20,
    parameter int RD_WAIT   = 2,
    parameter int WE_WIDTH  = 2
) (
    input  logic        clk_fpga,
    input  logic        clk_24mhz,
    input  logic        warmres_n,
    inout  wire  [7:0]  d,
    output logic [15:0] a,
    output logic        mema14,
    output logic        mema15,
    output logic        mema16,
    output logic        mema17,
    output logic        mema18,
    output logic        mema21,
    output logic        memwe_n,
    output logic        memoe_n,
    output logic        ram0cs_n,
    output logic        ram1cs_n,
    output logic        ram2cs_n,
    output logic        ram3cs_n,
    output logic        led_ok,
    output logic        led_err
);

    localparam int          CNT_W     = ADDR_BITS + 2;
    localparam logic [31:0] SEED_INIT = 32'h0000_0001;
    localparam logic [31:0] SEED_STEP = 32'h9E37_79B9;
    localparam logic [7:0]  WE_LAST   = 8'(WE_WIDTH);
    localparam logic [7:0]  RD_LAST   = 8'(RD_WAIT - 1);

    typedef enum logic [2:0] {
        ST_START,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RD_SETUP,
        ST_RD_WAIT,
        ST_RD_SAMPLE
    } state_t;

    // Galois LFSR step for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        lfsr_step = {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    // One-hot-low chip select for a chip number.
    function automatic logic [3:0] cs_decode(input logic [1:0] chip);
        case (chip)
            2'd0:    cs_decode = 4'b1110;
            2'd1:    cs_decode = 4'b1101;
            2'd2:    cs_decode = 4'b1011;
            2'd3:    cs_decode = 4'b0111;
            default: cs_decode = 4'b1111;
        endcase
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        lfsr_r;
    logic [31:0]        seed_r;
    logic [7:0]         dout_r;
    logic               drive_r;
    logic [7:0]         rd_data_r;
    logic [7:0]         wait_r;
    logic               we_n_r;
    logic               oe_n_r;
    logic [3:0]         cs_n_r;
    logic               led_ok_r;
    logic               led_err_r;
    logic               pass_err_r;

    logic               cnt_max_s;
    logic [CNT_W-1:0]   cnt_next_s;
    logic [1:0]         chip_next_s;
    logic [31:0]        lfsr_next_s;
    logic [31:0]        seed_next_s;
    logic               mismatch_s;
    logic [19:0]        addr_s;
    logic               unused_s;

    assign cnt_max_s   = &cnt_r;
    assign cnt_next_s  = cnt_r + CNT_W'(1);
    assign chip_next_s = cnt_next_s[CNT_W-1:CNT_W-2];
    assign lfsr_next_s = lfsr_step(lfsr_r);
    assign seed_next_s = seed_r + SEED_STEP;
    assign mismatch_s  = (rd_data_r != lfsr_r[7:0]);
    assign addr_s      = 20'(cnt_r[ADDR_BITS-1:0]);
    assign unused_s    = clk_24mhz;

    assign d        = drive_r ? dout_r : 8'hzz;
    assign a        = addr_s[15:0];
    assign mema14   = addr_s[14];
    assign mema15   = addr_s[15];
    assign mema16   = addr_s[16];
    assign mema17   = addr_s[17];
    assign mema18   = addr_s[18];
    assign mema21   = addr_s[19];
    assign memwe_n  = we_n_r;
    assign memoe_n  = oe_n_r;
    assign ram0cs_n = cs_n_r[0];
    assign ram1cs_n = cs_n_r[1];
    assign ram2cs_n = cs_n_r[2];
    assign ram3cs_n = cs_n_r[3];
    assign led_ok   = led_ok_r;
    assign led_err  = led_err_r;

    // Test sequencer: write phase, verify phase, seed update, loop forever.
    always_ff @(posedge clk_fpga) begin
        if (!warmres_n) begin
            state_r    <= ST_START;
            cnt_r      <= '0;
            lfsr_r     <= SEED_INIT;
            seed_r     <= SEED_INIT;
            dout_r     <= 8'h00;
            drive_r    <= 1'b0;
            rd_data_r  <= 8'h00;
            wait_r     <= 8'd0;
            we_n_r     <= 1'b1;
            oe_n_r     <= 1'b1;
            cs_n_r     <= 4'b1111;
            led_ok_r   <= 1'b0;
            led_err_r  <= 1'b0;
            pass_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_START: begin
                    cs_n_r  <= cs_decode(cnt_r[CNT_W-1:CNT_W-2]);
                    dout_r  <= lfsr_r[7:0];
                    drive_r <= 1'b1;
                    state_r <= ST_WR_SETUP;
                end
                ST_WR_SETUP: begin
                    we_n_r  <= 1'b0;
                    wait_r  <= 8'd1;
                    state_r <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (wait_r >= WE_LAST) begin
                        we_n_r  <= 1'b1;
                        state_r <= ST_WR_HOLD;
                    end else begin
                        wait_r  <= wait_r + 8'd1;
                    end
                end
                ST_WR_HOLD: begin
                    if (cnt_max_s) begin
                        // Last location written: restart the stream for verify.
                        cnt_r   <= '0;
                        lfsr_r  <= seed_r;
                        drive_r <= 1'b0;
                        oe_n_r  <= 1'b0;
                        cs_n_r  <= 4'b1110;
                        state_r <= ST_RD_SETUP;
                    end else begin
                        cnt_r   <= cnt_next_s;
                        lfsr_r  <= lfsr_next_s;
                        dout_r  <= lfsr_next_s[7:0];
                        cs_n_r  <= cs_decode(chip_next_s);
                        state_r <= ST_WR_SETUP;
                    end
                end
                ST_RD_SETUP: begin
                    if (RD_WAIT <= 1) begin
                        rd_data_r <= d;
                        oe_n_r    <= 1'b1;
                        cs_n_r    <= 4'b1111;
                        state_r   <= ST_RD_SAMPLE;
                    end else begin
                        wait_r    <= 8'd1;
                        state_r   <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (wait_r >= RD_LAST) begin
                        rd_data_r <= d;
                        oe_n_r    <= 1'b1;
                        cs_n_r    <= 4'b1111;
                        state_r   <= ST_RD_SAMPLE;
                    end else begin
                        wait_r    <= wait_r + 8'd1;
                    end
                end
                ST_RD_SAMPLE: begin
                    led_err_r <= led_err_r | mismatch_s;
                    if (cnt_max_s) begin
                        // Pass complete: report, advance the seed, rewrite.
                        if (!(pass_err_r | mismatch_s)) begin
                            led_ok_r <= ~led_ok_r;
                        end else begin
                            led_ok_r <= led_ok_r;
                        end
                        pass_err_r <= 1'b0;
                        seed_r     <= seed_next_s;
                        lfsr_r     <= seed_next_s;
                        dout_r     <= seed_next_s[7:0];
                        drive_r    <= 1'b1;
                        cnt_r      <= '0;
                        cs_n_r     <= 4'b1110;
                        state_r    <= ST_WR_SETUP;
                    end else begin
                        pass_err_r <= pass_err_r | mismatch_s;
                        cnt_r      <= cnt_next_s;
                        lfsr_r     <= lfsr_next_s;
                        oe_n_r     <= 1'b0;
                        cs_n_r     <= cs_decode(chip_next_s);
                        state_r    <= ST_RD_SETUP;
                    end
                end
                default: begin
                    drive_r <= 1'b0;
                    we_n_r  <= 1'b1;
                    oe_n_r  <= 1'b1;
                    cs_n_r  <= 4'b1111;
                    state_r <= ST_START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ramtest_main.sv
// tb_ramtest_main: four behavioural SRAMs on the shared bus, a scoreboard of
// expected write bytes regenerated from the seed sequence, and bus-legality
// monitoring on every clock.
module tb_ramtest_main;

    localparam int ADDR_BITS = 4;
    localparam int RD_WAIT   = 2;
    localparam int WE_WIDTH  = 2;

    logic        clk;
    logic        warmres_n;
    wire  [7:0]  d;
    logic [15:0] a;
    logic        mema14, mema15, mema16, mema17, mema18, mema21;
    logic        memwe_n, memoe_n;
    logic        ram0cs_n, ram1cs_n, ram2cs_n, ram3cs_n;
    logic        led_ok, led_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mem [4][16];
    logic        inject;
    logic [3:0]  cs_s;
    logic [1:0]  chip_s;
    logic        one_cs_s;
    logic [7:0]  sram_q_s;
    logic        sram_oe_s;

    logic [13:0] exp_q [$];
    logic [31:0] exp_seed;
    logic [7:0]  obs_first_q [$];
    int          wr_pass_cnt = 0;
    logic        prev_we = 1'b1;
    int          lo_cnt = 0;
    logic        skip_w = 1'b1;

    ramtest_main #(.ADDR_BITS(ADDR_BITS), .RD_WAIT(RD_WAIT), .WE_WIDTH(WE_WIDTH)) dut (
        .clk_fpga (clk),
        .clk_24mhz(clk),
        .warmres_n(warmres_n),
        .d        (d),
        .a        (a),
        .mema14   (mema14),
        .mema15   (mema15),
        .mema16   (mema16),
        .mema17   (mema17),
        .mema18   (mema18),
        .mema21   (mema21),
        .memwe_n  (memwe_n),
        .memoe_n  (memoe_n),
        .ram0cs_n (ram0cs_n),
        .ram1cs_n (ram1cs_n),
        .ram2cs_n (ram2cs_n),
        .ram3cs_n (ram3cs_n),
        .led_ok   (led_ok),
        .led_err  (led_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] r;
        logic        fb;
        fb    = s[0];
        r     = {fb, s[31:1]};
        r[21] = r[21] ^ fb;
        r[1]  = r[1] ^ fb;
        r[0]  = r[0] ^ fb;
        return r;
    endfunction

    // Expected write stream of one pass: 64 {index, byte} entries.
    task automatic fill_pass();
        logic [31:0] s;
        s = exp_seed;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back({6'(i), s[7:0]});
            s = lfsr_next(s);
        end
        exp_seed = exp_seed + 32'h9E37_79B9;
    endtask

    // Chip-select decode and SRAM read drive (bit 0 of chip2 addr5 optionally flipped).
    always_comb begin
        cs_s     = {ram3cs_n, ram2cs_n, ram1cs_n, ram0cs_n};
        chip_s   = 2'd0;
        one_cs_s = 1'b1;
        case (cs_s)
            4'b1110: chip_s = 2'd0;
            4'b1101: chip_s = 2'd1;
            4'b1011: chip_s = 2'd2;
            4'b0111: chip_s = 2'd3;
            default: one_cs_s = 1'b0;
        endcase
        sram_oe_s = one_cs_s && !memoe_n;
        sram_q_s  = mem[chip_s][a[3:0]] ^
                    {7'b0, inject && chip_s == 2'd2 && a[3:0] == 4'd5};
    end

    assign d = sram_oe_s ? sram_q_s : 8'hzz;

    // SRAM write.
    always @(negedge clk) begin
        if (!memwe_n && one_cs_s) mem[chip_s][a[3:0]] <= d;
    end

    // Bus legality, write scoreboard and write-pulse width.
    always @(negedge clk) begin
        logic [13:0] e;
        check_eq("we_oe_exclusive", {31'b0, memwe_n | memoe_n}, 32'd1);
        check_eq("cs_at_most_one", {31'b0, one_cs_s || cs_s == 4'b1111}, 32'd1);
        check_eq("a15_14_dup", {30'b0, a[15:14]}, {30'b0, mema15, mema14});
        check_eq("upper_addr_zero", {26'b0, a[15:4], mema16, mema17, mema18, mema21}, 32'd0);
        if (!warmres_n) begin
            lo_cnt = 0;
            skip_w = 1'b1;
        end else if (!memwe_n) begin
            if (prev_we) begin
                if (exp_q.size() == 0) fill_pass();
                e = exp_q.pop_front();
                skip_w = 1'b0;
                check_eq("wr_one_cs", {31'b0, one_cs_s}, 32'd1);
                check_eq("wr_index", {26'b0, chip_s, a[3:0]}, {26'b0, e[13:8]});
                check_eq("wr_data", {24'b0, d}, {24'b0, e[7:0]});
                if (e[13:8] == 6'd0) begin
                    obs_first_q.push_back(d);
                    wr_pass_cnt++;
                end
            end
            lo_cnt++;
        end else if (!prev_we) begin
            if (!skip_w) check_eq("we_width", lo_cnt, WE_WIDTH);
            lo_cnt = 0;
        end
        prev_we = memwe_n;
    end

    task automatic wait_led_ok(input logic exp, input string tag);
        int n;
        n = 0;
        while (led_ok !== exp && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'b0, led_ok}, {31'b0, exp});
    endtask

    task automatic wait_passes(input int target);
        int n;
        n = 0;
        while (wr_pass_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("pass_start_seen", {31'b0, wr_pass_cnt >= target}, 32'd1);
    endtask

    initial begin
        int n;
        warmres_n = 1'b0;
        inject    = 1'b0;
        exp_seed  = 32'h0000_0001;
        repeat (10) @(negedge clk);
        check_eq("rst_cs", {28'b0, cs_s}, 32'hF);
        check_eq("rst_we", {31'b0, memwe_n}, 32'd1);
        check_eq("rst_oe", {31'b0, memoe_n}, 32'd1);
        check_eq("rst_led_ok", {31'b0, led_ok}, 32'd0);
        check_eq("rst_led_err", {31'b0, led_err}, 32'd0);

        warmres_n = 1'b1;
        @(negedge clk);
        check_eq("first_setup_cs", {28'b0, cs_s}, 32'hE);
        check_eq("first_setup_addr", {16'b0, a}, 32'd0);
        check_eq("first_setup_we_oe", {30'b0, memwe_n, memoe_n}, 32'd3);

        // Pass 1 clean.
        wait_led_ok(1'b1, "pass1_led_ok");
        check_eq("pass1_led_err", {31'b0, led_err}, 32'd0);

        // Pass 2 uses the next seed; its first byte differs.
        wait_passes(2);
        check_eq("pass2_first_byte", {24'b0, obs_first_q[1]}, 32'hBA);
        check_eq("pass2_first_diff", {31'b0, obs_first_q[1] != obs_first_q[0]}, 32'd1);

        // Corrupt chip2 addr5 on read during pass 2.
        inject = 1'b1;
        n = 0;
        while (led_err !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("inject_led_err", {31'b0, led_err}, 32'd1);
        check_eq("inject_err_point", {26'b0, chip_s, a[3:0]}, 32'd38);
        inject = 1'b0;

        wait_passes(3);
        check_eq("bad_pass_led_ok", {31'b0, led_ok}, 32'd1);
        check_eq("bad_pass_led_err", {31'b0, led_err}, 32'd1);
        wait_led_ok(1'b0, "pass3_led_ok");
        check_eq("pass3_led_err_sticky", {31'b0, led_err}, 32'd1);

        // Reset in the middle of a write pulse.
        n = 0;
        while (memwe_n !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("found_we_pulse", {31'b0, memwe_n}, 32'd0);
        warmres_n = 1'b1;
        warmres_n = 1'b0;
        @(negedge clk);
        check_eq("abort_we", {31'b0, memwe_n}, 32'd1);
        check_eq("abort_cs", {28'b0, cs_s}, 32'hF);
        check_eq("abort_oe", {31'b0, memoe_n}, 32'd1);
        check_eq("abort_leds", {30'b0, led_ok, led_err}, 32'd0);
        exp_q.delete();
        exp_seed = 32'h0000_0001;
        @(negedge clk);
        warmres_n = 1'b1;
        @(negedge clk);
        check_eq("restart_cs", {28'b0, cs_s}, 32'hE);
        check_eq("restart_addr", {16'b0, a}, 32'd0);
        wait_led_ok(1'b1, "restart_pass_led_ok");
        check_eq("restart_pass_led_err", {31'b0, led_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ramtest_main.md
Name: ramtest_main

Overview:
FPGA top-level SRAM tester for the revC board. It drives four 8-bit asynchronous SRAM chips that share one address/data/OE/WE bus, with a separate chip-select per chip. Each pass writes a pseudo-random byte stream to every location of every chip, then reads all locations back and compares them against the regenerated stream. Pass/fail status is reported on two LED outputs.

Parameters:
ADDR_BITS, 20, address width per chip (1 MB per chip); reduced values shorten simulation.
RD_WAIT, 2, clocks from OE/CS assertion to data sample.
WE_WIDTH, 2, clocks memwe_n is held low per write.

Ports:
clk_fpga  input  1  system clock (24 MHz); all logic is on its rising edge.
clk_24mhz  input  1  pin-compatibility input, unused; may be tied to the same source.
warmres_n  input  1  reset, synchronous, active-low.
d  inout  8  SRAM data bus.
a  output  16  SRAM address bits [15:0]; a[15:14] duplicate mema15/mema14.
mema14, mema15, mema16, mema17, mema18  output  1 each  SRAM address bits 14..18.
mema21  output  1  SRAM address bit 19.
memwe_n  output  1  write enable, active-low.
memoe_n  output  1  output enable, active-low.
ram0cs_n, ram1cs_n, ram2cs_n, ram3cs_n  output  1 each  chip selects, active-low.
led_ok  output  1  toggles at the end of each passing verify pass.
led_err  output  1  sticky mismatch flag.

Behaviour:
- Reset is sampled on the clk_fpga edge while warmres_n=0. On reset: all csN_n=1, memwe_n=1, memoe_n=1, d=Z, address=0, led_ok=0, led_err=0, seed=32'h0000_0001, state=WR_SETUP on the first clock after release. A reset in mid-cycle aborts the access and restores all of these values within one clock.
- Linear counter {chip[1:0], addr[ADDR_BITS-1:0]} runs from 0 to the maximum. Address bits above ADDR_BITS-1 are driven 0. Only the cs_n of the selected chip is low during an access.
- Pattern: 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1, loaded with seed at the start of both the write phase and the verify phase. Each byte's data is lfsr[7:0], and the LFSR steps once per byte.
- Write cycle, per location:
  - WR_SETUP (1 clk): address and cs valid, d driven with data, we_n=1.
  - WR_PULSE (WE_WIDTH clks): we_n=0.
  - WR_HOLD (1 clk): we_n=1, d still driven, then cs released.
  - oe_n stays 1 throughout the write phase.
- Read cycle, per location:
  - RD_SETUP (1 clk): address and cs valid, oe_n=0, d=Z.
  - RD_WAIT: oe_n stays low until RD_WAIT clocks have elapsed since RD_SETUP.
  - RD_SAMPLE: d is captured and compared, then oe_n and cs_n return to 1.
- d is driven only in WR_SETUP, WR_PULSE and WR_HOLD; it is Z at all other times.
- Mismatch: sets led_err=1 (sticky until reset). Testing continues.
- End of the write phase, at the last counter value: go to the verify phase with the counter at 0.
- End of the verify phase: if no mismatch occurred in this pass, toggle led_ok. Then seed <= seed + 32'h9E37_79B9 and start a new write phase. Testing loops indefinitely.
- Counter wrap is from the maximum value to 0, with no idle gap beyond one state transition.
- At most one of we_n and oe_n is low at any time. Address and cs are stable whenever we_n is low.

Test Plan:
1. Hold warmres_n=0 for 10 clks -> all cs_n=1, we_n=1, oe_n=1, d=Z, led_ok=0, led_err=0; first write starts on the clock after release, at chip0 addr 0 with data 8'h01 (lfsr[7:0] of seed 1).
2. ADDR_BITS=4, SRAM behavioural models attached -> write phase covers 64 bytes in order ram0..ram3; memwe_n is low exactly WE_WIDTH clks per byte; d=Z during all reads.
3. Same setup, complete one write+verify pass -> led_ok toggles 0->1, led_err=0; second pass uses seed 32'h9E37_79BA and its first written byte differs from the first pass.
4. Model flips bit 0 at chip2 addr 5 -> led_err=1 after that read sample, it stays 1 through later passes, and led_ok does not toggle at the end of that pass.
5. Assert warmres_n=0 during WR_PULSE -> memwe_n=1 and cs_n=1 on the next clock; after release, the write phase restarts at address 0 with seed 1.
6. Check bus legality throughout every scenario -> memwe_n and memoe_n are never both 0; no two cs_n are ever 0 at once; a[15:14] always equal {mema15, mema14}.
